// File: rtl/i2s_receiver.sv
// I2S slave receiver: synchronises the external bit clock, word select and data into clk,
// deserialises left/right slots MSB-first and presents stereo words on a valid/ready port.
module i2s_receiver #(
  parameter int SAMPLE_BITS = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       i2s_sclk,
  input  logic                       i2s_lrclk,
  input  logic                       i2s_sdata,
  output logic [2*SAMPLE_BITS-1:0]   sample_data,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int CW = $clog2(SAMPLE_BITS + 1);

  typedef enum logic [1:0] {IDLE, ALIGN, LEFT, RIGHT} state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]   lr_sync_q, lr_sync_d;
  logic [SYNC_STAGES-1:0]   sd_sync_q, sd_sync_d;
  logic                     sclk_prev_q, sclk_prev_d;
  logic                     ws_prev_q, ws_prev_d;
  logic [CW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_BITS-1:0]   left_q, left_d;
  logic [SAMPLE_BITS-1:0]   right_q, right_d;
  logic                     pending_q, pending_d;
  logic [2*SAMPLE_BITS-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     ovf_q, ovf_d;

  logic                     sclk_s, lr_s, sd_s;
  logic                     rise, change, accept, load;
  logic [SAMPLE_BITS-1:0]   cur, shifted, closed;
  logic [CW-1:0]            cnt_n, shamt;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign lr_s   = lr_sync_q[SYNC_STAGES-1];
  assign sd_s   = sd_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i2s_sclk};
    lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], i2s_lrclk};
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], i2s_sdata};
    sclk_prev_d = sclk_s;
    ws_prev_d   = ws_prev_q;
    bit_cnt_d   = bit_cnt_q;
    left_d      = left_q;
    right_d     = right_q;
    pending_d   = 1'b0;
    data_d      = data_q;
    valid_d     = valid_q;
    ovf_d       = ovf_q;

    rise    = sclk_s & ~sclk_prev_q;
    change  = rise && (lr_s != ws_prev_q);
    cur     = (state_q == RIGHT) ? right_q : left_q;
    shifted = cur;
    cnt_n   = bit_cnt_q;
    if (bit_cnt_q < CW'(SAMPLE_BITS)) begin
      shifted = {cur[SAMPLE_BITS-2:0], sd_s};
      cnt_n   = bit_cnt_q + CW'(1);
    end
    // Left-justify a short slot: the shift also pushes out stale bits of the previous word
    shamt  = CW'(SAMPLE_BITS) - cnt_n;
    closed = shifted << shamt;

    if (rise) begin
      ws_prev_d = lr_s;
    end

    case (state_q)
      IDLE: begin
        if (enable) state_d = ALIGN;
      end
      ALIGN: begin
        if (change && !lr_s) begin
          bit_cnt_d = '0;
          state_d   = LEFT;
        end
      end
      LEFT, RIGHT: begin
        if (change) begin
          bit_cnt_d = '0;
          if (state_q == LEFT) begin
            left_d = closed;
            if (lr_s) state_d = RIGHT;
          end else begin
            right_d = closed;
            if (!lr_s) begin
              state_d   = LEFT;
              pending_d = 1'b1;
            end
          end
        end else if (rise) begin
          bit_cnt_d = cnt_n;
          if (state_q == LEFT) left_d = shifted;
          else                 right_d = shifted;
        end
      end
      default: state_d = IDLE;
    endcase

    accept = valid_q && sample_ready;
    load   = pending_q && (!valid_q || accept);
    if (load) begin
      data_d  = {left_q, right_q};
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end

    if (overflow_clr)          ovf_d = 1'b0;
    if (pending_q && !load)    ovf_d = 1'b1;

    // Disabling discards any partial word and the held output; overflow is kept
    if (!enable) begin
      state_d   = IDLE;
      left_d    = '0;
      right_d   = '0;
      bit_cnt_d = '0;
      valid_d   = 1'b0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      ws_prev_q   <= 1'b0;
      bit_cnt_q   <= '0;
      left_q      <= '0;
      right_q     <= '0;
      pending_q   <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      sd_sync_q   <= sd_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ws_prev_q   <= ws_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      left_q      <= left_d;
      right_q     <= right_d;
      pending_q   <= pending_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives an I2S master at clk/16 and checks received words.
module tb_i2s_receiver;

  logic        clk = 1'b0;
  logic        rst, enable, sclk, lr, sd, ready, clr;
  logic [47:0] data;
  logic        valid, ovf;

  always #5 clk = ~clk;

  i2s_receiver dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .i2s_sclk     (sclk),
    .i2s_lrclk    (lr),
    .i2s_sdata    (sd),
    .sample_data  (data),
    .sample_valid (valid),
    .sample_ready (ready),
    .overflow     (ovf),
    .overflow_clr (clr)
  );

  int          total = 0;
  int          bad   = 0;
  int          vcnt  = 0;
  logic [47:0] got[$];

  // Records every accepted word and the number of cycles valid was high
  always @(negedge clk) begin
    if (valid) vcnt++;
    if (valid && ready && !rst) got.push_back(data);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bits lo..hi of one slot; the last slot bit is sent with the next channel's word select
  task automatic send_bits(input logic ch, input logic [23:0] val, input int slot,
                           input logic fill, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      sclk = 1'b0;
      lr   = (i == slot - 1) ? ~ch : ch;
      sd   = (i < 24) ? val[23 - i] : fill;
      tick(8);
      sclk = 1'b1;
      tick(8);
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int slot,
                            input logic fill_l, input logic fill_r);
    send_bits(1'b0, l, slot, fill_l, 0, slot - 1);
    send_bits(1'b1, r, slot, fill_r, 0, slot - 1);
    tick(4);
  endtask

  // Tail of a right slot so the receiver sees a change edge to the left channel
  task automatic preamble();
    sclk = 1'b0; lr = 1'b1; sd = 1'b0; tick(8);
    sclk = 1'b1; tick(8);
    sclk = 1'b0; lr = 1'b0; tick(8);
    sclk = 1'b1; tick(8);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; sclk = 1'b0; lr = 1'b0; sd = 1'b0; ready = 1'b1; clr = 1'b0;
    tick(3);
    check("rst_data", 64'(data), 64'h0);
    check("rst_valid", 64'(valid), 64'h0);
    check("rst_ovf", 64'(ovf), 64'h0);
    rst = 1'b0;
    tick(2);

    // 64fs, 32-bit slots
    enable = 1'b1;
    tick(1);
    preamble();
    got.delete();
    vcnt = 0;
    send_frame(24'hA5A5A5, 24'h3C3C3C, 32, 1'b0, 1'b1);
    check("t1_count", 64'(got.size()), 64'd1);
    check("t1_word", 64'(got[0]), 64'hA5A5A5_3C3C3C);
    check("t1_valid_cycles", 64'(vcnt), 64'd1);
    check("t1_valid_low", 64'(valid), 64'h0);
    check("t1_ovf", 64'(ovf), 64'h0);

    // 48fs, 24-bit slots, four frames
    got.delete();
    repeat (4) send_frame(24'h800001, 24'h7FFFFF, 24, 1'b0, 1'b0);
    check("t2_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("t2_word", 64'(got[i]), 64'h800001_7FFFFF);

    // 16-bit slots, zero-filled LSBs
    got.delete();
    send_frame(24'h123400, 24'hABCD00, 16, 1'b0, 1'b0);
    check("t3_count", 64'(got.size()), 64'd1);
    check("t3_word", 64'(got[0]), 64'h123400_ABCD00);

    // Back-pressure and overflow
    ready = 1'b0;
    got.delete();
    send_frame(24'h000001, 24'h000002, 24, 1'b0, 1'b0);
    send_frame(24'h000003, 24'h000004, 24, 1'b0, 1'b0);
    check("t4_hold_data", 64'(data), 64'h000001_000002);
    check("t4_hold_valid", 64'(valid), 64'h1);
    check("t4_ovf_set", 64'(ovf), 64'h1);
    check("t4_none_taken", 64'(got.size()), 64'd0);
    ready = 1'b1;
    tick(2);
    check("t4_valid_drop", 64'(valid), 64'h0);
    check("t4_taken", 64'(got.size()), 64'd1);
    check("t4_taken_word", 64'(got[0]), 64'h000001_000002);
    check("t4_ovf_sticky", 64'(ovf), 64'h1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("t4_ovf_clr", 64'(ovf), 64'h0);

    // Enable rising mid right slot discards that frame
    enable = 1'b0;
    tick(2);
    got.delete();
    send_bits(1'b0, 24'h111111, 24, 1'b0, 0, 23);
    send_bits(1'b1, 24'h222222, 24, 1'b0, 0, 9);
    enable = 1'b1;
    send_bits(1'b1, 24'h222222, 24, 1'b0, 10, 23);
    tick(4);
    check("t5_partial_dropped", 64'(got.size()), 64'd0);
    send_frame(24'h5A5A5A, 24'h0F0F0F, 24, 1'b0, 1'b0);
    check("t5_count", 64'(got.size()), 64'd1);
    check("t5_word", 64'(got[0]), 64'h5A5A5A_0F0F0F);

    // Enable falling mid left slot
    ready = 1'b0;
    got.delete();
    send_frame(24'h654321, 24'h123456, 24, 1'b0, 1'b0);
    check("t5b_valid_before", 64'(valid), 64'h1);
    send_bits(1'b0, 24'h777777, 24, 1'b0, 0, 11);
    enable = 1'b0;
    tick(1);
    check("t5b_valid_cleared", 64'(valid), 64'h0);
    check("t5b_ovf_held", 64'(ovf), 64'h0);
    send_bits(1'b0, 24'h777777, 24, 1'b0, 12, 23);
    send_bits(1'b1, 24'h888888, 24, 1'b0, 0, 23);
    tick(4);
    check("t5b_no_word", 64'(valid), 64'h0);
    check("t5b_idle", 64'(dut.state_q), 64'd0);

    // Asynchronous reset mid word
    enable = 1'b1;
    tick(1);
    preamble();
    send_frame(24'hABCDEF, 24'h13579B, 24, 1'b0, 1'b0);
    send_frame(24'h2468AC, 24'hFEDCBA, 24, 1'b0, 1'b0);
    check("t6_pre_valid", 64'(valid), 64'h1);
    check("t6_pre_ovf", 64'(ovf), 64'h1);
    send_bits(1'b0, 24'h999999, 24, 1'b0, 0, 7);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t6_rst_data", 64'(data), 64'h0);
    check("t6_rst_valid", 64'(valid), 64'h0);
    check("t6_rst_ovf", 64'(ovf), 64'h0);
    tick(2);
    rst = 1'b0;
    tick(2);
    ready = 1'b1;
    got.delete();
    preamble();
    send_frame(24'hC0FFEE, 24'hBADA55, 24, 1'b0, 1'b0);
    check("t6_count", 64'(got.size()), 64'd1);
    check("t6_word", 64'(got[0]), 64'hC0FFEE_BADA55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
